// File: rtl/psg_pdm_out.sv
// PSG audio output stage: 2-entry sample FIFO drained at a fixed sample rate
// into a first-order sigma-delta modulator that drives a 1-bit PDM pin.
module psg_pdm_out #(
  parameter int WIDTH = 8,
  parameter int DIV   = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             mute,
  output logic             pdm_out,
  output logic             sample_tick,
  output logic             underrun
);

  localparam int              CW       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   DIV_LAST = CW'(DIV - 1);
  localparam logic [WIDTH-1:0] MIDSCALE = WIDTH'(1) << (WIDTH - 1);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CW-1:0]    div_cnt_q, div_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             pdm_q, pdm_d;

  logic             push, pop;
  logic [WIDTH-1:0] x;
  logic [WIDTH:0]   sum;

  assign s_ready     = (count_q != 2'd2);
  assign sample_tick = (div_cnt_q == DIV_LAST);
  assign underrun    = sample_tick && (count_q == 2'd0);
  assign push        = s_valid && s_ready;
  // A sample pushed into an empty FIFO on the tick cycle waits for the next tick.
  assign pop         = sample_tick && (count_q != 2'd0);
  assign pdm_out     = pdm_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    hold_d    = hold_q;
    div_cnt_d = sample_tick ? '0 : div_cnt_q + CW'(1);

    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      hold_d   = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Mute only gates the modulator input; the accumulator keeps its phase.
    x     = mute ? '0 : hold_q;
    sum   = {1'b0, acc_q} + {1'b0, x};
    acc_d = sum[WIDTH-1:0];
    pdm_d = sum[WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      div_cnt_q <= '0;
      hold_q    <= MIDSCALE;
      acc_q     <= '0;
      pdm_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      div_cnt_q <= div_cnt_d;
      hold_q    <= hold_d;
      acc_q     <= acc_d;
      pdm_q     <= pdm_d;
    end
  end

  // NOTE: FIFO storage is left unreset; count_q gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

endmodule
